// File: rtl/rv_defs.sv
// Shared definitions for the RV32IM multi-cycle controller: opcodes,
// FSM state encoding, datapath select encodings and the decode bundle.
// The MULDIV state only exists when RV32M_MULDIV_EN is defined.
package rv_defs;

  localparam int INST_WIDTH = 32;
  localparam int OPCODE_W   = 7;

  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_ALUI   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_ALU    = 7'b0110011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
`ifdef RV32M_MULDIV_EN
    ST_MULDIV = 3'd3,
`endif
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // Opcode classification of the latched IR
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;
    logic is_alu;
    logic is_muldiv;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational opcode classification and legality check.
// With RV32M_MULDIV_EN undefined, OP_ALU with the M-extension funct7 is illegal.
module rv_ctrl_decode
  import rv_defs::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [6:0]          funct7,
  output dec_t                dec
);

  logic known;
  logic mul_enc;

  // Classify opcode; anything outside the base set traps
  always_comb begin
    dec           = '0;
    dec.is_load   = (opcode == OP_LOAD);
    dec.is_store  = (opcode == OP_STORE);
    dec.is_branch = (opcode == OP_BRANCH);
    dec.is_jal    = (opcode == OP_JAL);
    dec.is_jalr   = (opcode == OP_JALR);
    dec.is_lui    = (opcode == OP_LUI);
    dec.is_auipc  = (opcode == OP_AUIPC);
    dec.is_alu    = (opcode == OP_ALU);
    mul_enc       = dec.is_alu && (funct7 == FUNCT7_MULDIV);
    known         = dec.is_load | dec.is_store | dec.is_branch | dec.is_jal |
                    dec.is_jalr | dec.is_lui | dec.is_auipc | dec.is_alu |
                    (opcode == OP_ALUI);
`ifdef RV32M_MULDIV_EN
    dec.is_muldiv = mul_enc;
    dec.illegal   = !known;
`else
    dec.is_muldiv = 1'b0;
    dec.illegal   = !known || mul_enc;
`endif
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle main controller for the RV32IM core.
// State is registered; enables/selects decode from state, IR and the
// memory/comparator handshakes. Optional M extension: RV32M_MULDIV_EN.
module rv_multicycle_ctrl
  import rv_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INST_WIDTH-1:0] i_inst,
  input  logic                  i_imem_ready,
  input  logic                  i_dmem_ready,
  input  logic                  i_branch_taken,
  input  logic                  i_muldiv_done,
  output logic                  o_imem_req,
  output logic                  o_ir_we,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic                  o_reg_we,
  output logic                  o_pc_we,
  output logic [1:0]            o_pc_sel,
  output logic                  o_alu_src_a,
  output logic                  o_alu_src_b,
  output logic [1:0]            o_wb_sel,
  output logic                  o_muldiv_start,
  output logic                  o_illegal,
  output logic [CNT_WIDTH-1:0]  o_retired,
  output logic [31:0]           o_pc_reset_val
);

  state_t state;
  dec_t   dec;
  logic   alu_a, alu_b;
  logic   unused_bits;

  rv_ctrl_decode u_dec (
    .opcode (i_inst[6:0]),
    .funct7 (i_inst[31:25]),
    .dec    (dec)
  );

  // Operand fields and the rest of the IR feed the datapath directly
`ifdef RV32M_MULDIV_EN
  assign unused_bits = ^i_inst[24:7];
`else
  assign unused_bits = ^{i_inst[24:7], dec.is_muldiv};
`endif

  assign o_pc_reset_val = RESET_PC;
  assign alu_a = dec.is_auipc;
  assign alu_b = !(dec.is_alu || dec.is_branch);

  // State sequencing; reset aborts whatever instruction is in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:  if (i_imem_ready) state <= ST_DECODE;
        ST_DECODE: state <= dec.illegal ? ST_TRAP : ST_EXEC;
        ST_EXEC: begin
          if (dec.is_branch)                     state <= ST_FETCH;
          else if (dec.is_load || dec.is_store)  state <= ST_MEM;
`ifdef RV32M_MULDIV_EN
          else if (dec.is_muldiv)                state <= ST_MULDIV;
`endif
          else                                   state <= ST_WB;
        end
`ifdef RV32M_MULDIV_EN
        ST_MULDIV: if (i_muldiv_done) state <= ST_WB;
`endif
        ST_MEM:    if (i_dmem_ready) state <= dec.is_store ? ST_FETCH : ST_WB;
        ST_WB:     state <= ST_FETCH;
        ST_TRAP:   state <= ST_TRAP;
        default:   state <= ST_FETCH;
      endcase
    end
  end

  // Datapath controls; everything held low while reset is asserted
  always_comb begin
    o_imem_req     = 1'b0;
    o_ir_we        = 1'b0;
    o_dmem_req     = 1'b0;
    o_dmem_we      = 1'b0;
    o_reg_we       = 1'b0;
    o_pc_we        = 1'b0;
    o_pc_sel       = PC_SEL_PLUS4;
    o_alu_src_a    = 1'b0;
    o_alu_src_b    = 1'b0;
    o_wb_sel       = WB_SEL_ALU;
    o_muldiv_start = 1'b0;
    o_illegal      = 1'b0;
    if (!i_rst) begin
      case (state)
        ST_FETCH: begin
          o_imem_req = 1'b1;
          o_ir_we    = i_imem_ready;
        end
        ST_EXEC: begin
          o_alu_src_a = alu_a;
          o_alu_src_b = alu_b;
          if (dec.is_branch) begin
            o_pc_we  = 1'b1;
            o_pc_sel = i_branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
          end
`ifdef RV32M_MULDIV_EN
          o_muldiv_start = dec.is_muldiv;
`endif
        end
`ifdef RV32M_MULDIV_EN
        ST_MULDIV: begin
          o_alu_src_a = alu_a;
          o_alu_src_b = alu_b;
        end
`endif
        ST_MEM: begin
          o_alu_src_a = alu_a;
          o_alu_src_b = alu_b;
          o_dmem_req  = 1'b1;
          o_dmem_we   = dec.is_store;
          o_pc_we     = dec.is_store && i_dmem_ready;
        end
        ST_WB: begin
          o_alu_src_a = alu_a;
          o_alu_src_b = alu_b;
          o_reg_we    = 1'b1;
          o_pc_we     = 1'b1;
          if (dec.is_load)                    o_wb_sel = WB_SEL_LOAD;
          else if (dec.is_jal || dec.is_jalr) o_wb_sel = WB_SEL_PC4;
          else if (dec.is_lui)                o_wb_sel = WB_SEL_IMM;
          if (dec.is_jal)                     o_pc_sel = PC_SEL_BRANCH;
          else if (dec.is_jalr)               o_pc_sel = PC_SEL_JALR;
        end
        ST_TRAP:  o_illegal = 1'b1;
        default:  ;
      endcase
    end
  end

  // Retired count steps with every PC update
  always_ff @(posedge i_clk) begin
    if (i_rst)        o_retired <= '0;
    else if (o_pc_we) o_retired <= o_retired + CNT_WIDTH'(1);
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle main controller for the RV32IM core. It sequences fetch, decode, execute, memory and writeback over the shared datapath: the register file, the ALU, the immediate sign-extension unit and the MUL/DIV unit. It generates all datapath enables and mux selects from the latched instruction register. The immediate unit is driven directly from the IR and IR[6:0]. This block only selects when its output is consumed.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (datapath side; exported here as o_pc_reset_val).
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  synchronous, active-high reset.
i_inst  in  32  current IR contents (latched instruction).
i_imem_ready  in  1  instruction memory has data valid this cycle.
i_dmem_ready  in  1  data memory access completes this cycle.
i_branch_taken  in  1  comparator result for current branch (valid in EXEC).
i_muldiv_done  in  1  MUL/DIV result valid (one-cycle pulse).
o_imem_req  out  1  instruction fetch request.
o_ir_we  out  1  latch instruction register.
o_dmem_req  out  1  data memory request.
o_dmem_we  out  1  data memory write (store).
o_reg_we  out  1  register file write.
o_pc_we  out  1  PC update.
o_pc_sel  out  2  0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1.
o_alu_src_a  out  1  0 rs1, 1 PC.
o_alu_src_b  out  1  0 rs2, 1 immediate.
o_wb_sel  out  2  0 ALU, 1 load data, 2 PC+4, 3 immediate.
o_muldiv_start  out  1  one-cycle start pulse to MUL/DIV unit.
o_illegal  out  1  sticky illegal-instruction flag.
o_retired  out  CNT_WIDTH  retired-instruction count.
o_pc_reset_val  out  32  constant RESET_PC.

Behaviour:
- Reset: state=FETCH. All 1-bit outputs 0, selects 0, o_retired=0. Reset mid-instruction aborts it; no write enable asserts in the reset cycle.
- States: FETCH, DECODE, EXEC, MULDIV, MEM, WB, TRAP. Registered Moore FSM. Outputs are decoded from the state plus the IR opcode.
- FETCH: o_imem_req=1 held until i_imem_ready. The ready cycle pulses o_ir_we and moves to DECODE. Otherwise stay.
- DECODE: 1 cycle. Any opcode outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU, ALUI goes to TRAP. Otherwise go to EXEC.
- EXEC: 1 cycle.
  - alu_src_a=1 for AUIPC.
  - alu_src_b=1 for all opcodes except ALU and BRANCH.
  - BRANCH: o_pc_we=1, pc_sel = i_branch_taken ? 1 : 0, retire, go to FETCH.
  - LOAD/STORE: go to MEM.
  - ALU with funct7=0000001: o_muldiv_start=1, go to MULDIV.
  - All other opcodes: go to WB.
- MULDIV: wait for i_muldiv_done, then go to WB. A done pulse seen in EXEC is ignored.
- MEM: o_dmem_req=1 held until i_dmem_ready; o_dmem_we=1 for STORE.
  - STORE on ready: o_pc_we=1, pc_sel=0, retire, go to FETCH.
  - LOAD on ready: go to WB.
- WB: 1 cycle, o_reg_we=1, o_pc_we=1.
  - wb_sel: 1 LOAD, 2 JAL/JALR, 3 LUI, 0 otherwise.
  - pc_sel: 1 JAL, 2 JALR, 0 otherwise.
  - Retire, go to FETCH.
- TRAP: absorbing state until reset. o_illegal=1; no req or write enables.
- Retire: o_retired increments by 1 in the same cycle o_pc_we=1 (except trap). Wraps modulo 2^CNT_WIDTH.
- Minimum latency (zero-wait memories):
  - BRANCH: 3 cycles.
  - ALU/ALUI/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- rd=x0 writes still assert o_reg_we; the register file discards them.

Optional Feature:
RV32M_MULDIV_EN.
- Defined: funct7=0000001 on OP_ALU follows the MULDIV path above.
- Undefined: MULDIV state is absent, o_muldiv_start is tied 0, and funct7=0000001 on OP_ALU is illegal and goes to TRAP from DECODE.

Decomposition:
- Shared package/header rv_defs: INST_WIDTH, OPCODE width, all OP_* opcode constants, state encoding, PC_SEL_*/WB_SEL_* encodings, FUNCT7_MULDIV.
- One natural sub-module, rv_ctrl_decode: combinational opcode classification and legality check (is_load, is_store, is_branch, is_jal, is_jalr, is_muldiv, illegal). The FSM and counter stay in rv_multicycle_ctrl.

Test Plan:
- addi x1,x0,5 (0x00500093), imem_ready immediate:
  - FETCH→DECODE→EXEC→WB in 4 cycles.
  - WB has reg_we=1, wb_sel=0, alu_src_b=1, pc_sel=0.
  - o_retired 0→1.
- lw x2,0(x1) (0x0000A103) with dmem_ready delayed 3 cycles:
  - dmem_req held 4 cycles, dmem_we=0.
  - WB wb_sel=1; total 8 cycles.
- sw x2,4(x1) (0x0020A223):
  - MEM has dmem_we=1.
  - No reg_we in any cycle; pc_we in MEM ready cycle; retired+1.
- beq x0,x0,8 (0x00000463):
  - With branch_taken=1: EXEC has pc_we=1, pc_sel=1, 3 cycles, no reg_we.
  - Repeat with taken=0: pc_sel=0.
- mul x3,x1,x2 (0x022081B3), done after 5 cycles:
  - One muldiv_start pulse; state holds in MULDIV; WB follows the done cycle.
  - Without RV32M_MULDIV_EN: o_illegal=1 after DECODE.
- Illegal 0x00000000:
  - TRAP, o_illegal stuck at 1, no imem_req.
  - Assert i_rst mid-trap: next cycle FETCH, o_illegal=0, o_retired=0.
